// File: rtl/exec_mul_unit.sv
// Iterative radix-2^BITS_PER_CYCLE multiplier for the Execute stage.
// Stalls the pipeline while computing and strobes the result for one cycle.
module exec_mul_unit #(
    parameter int SIZE           = 48,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            MulStartE,
    input  logic            SignedE,
    input  logic            HighE,
    input  logic [SIZE-1:0] SrcAE,
    input  logic [SIZE-1:0] SrcBE,
    input  logic [3:0]      WA3E,
    input  logic            Abort,
    output logic            MulBusy,
    output logic            MulDone,
    output logic [SIZE-1:0] MulResult,
    output logic [3:0]      MulWA3,
    output logic            MulN,
    output logic            MulZ
);

    localparam int N  = SIZE / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * SIZE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_mcand;
    logic [SIZE-1:0] r_mplier;
    logic [CW-1:0]   r_cnt;
    logic            r_sign;
    logic            r_high;
    logic [3:0]      r_wa3;
    logic [SIZE-1:0] r_result;
    logic [3:0]      r_wa3_out;
    logic            r_n;
    logic            r_z;

    logic            w_start;
    logic [SIZE-1:0] w_mag_a;
    logic [SIZE-1:0] w_mag_b;
    logic [PW-1:0]   w_pp;
    logic [PW-1:0]   w_prod;
    logic [SIZE-1:0] w_sel;

    assign w_start = MulStartE & ~Abort;

    assign w_mag_a = (SignedE & SrcAE[SIZE-1]) ? (~SrcAE + SIZE'(1)) : SrcAE;
    assign w_mag_b = (SignedE & SrcBE[SIZE-1]) ? (~SrcBE + SIZE'(1)) : SrcBE;

    // Partial product for the low multiplier digit, as shifted adds.
    always_comb begin
        w_pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_mplier[i]) begin
                w_pp = w_pp + (r_mcand << i);
            end
        end
    end

    assign w_prod = r_sign ? (~r_acc + PW'(1)) : r_acc;
    assign w_sel  = r_high ? w_prod[PW-1:SIZE] : w_prod[SIZE-1:0];

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_start) w_next = S_CALC;
            S_CALC: if (r_cnt == CW'(N - 1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (Abort) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_high    <= 1'b0;
            r_wa3     <= '0;
            r_result  <= '0;
            r_wa3_out <= '0;
            r_n       <= 1'b0;
            r_z       <= 1'b0;
        end else if (!Abort) begin
            unique case (r_state)
                S_IDLE: begin
                    if (MulStartE) begin
                        r_mcand  <= {{SIZE{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_sign   <= SignedE & (SrcAE[SIZE-1] ^ SrcBE[SIZE-1]);
                        r_high   <= HighE;
                        r_wa3    <= WA3E;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_CALC: begin
                    r_acc    <= r_acc + w_pp;
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= r_mplier >> BITS_PER_CYCLE;
                    r_cnt    <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    r_result  <= w_sel;
                    r_wa3_out <= r_wa3;
                    r_n       <= w_sel[SIZE-1];
                    r_z       <= (w_sel == '0);
                end
                default: ;
            endcase
        end
    end

    assign MulBusy   = ~Abort & (((r_state == S_IDLE) & MulStartE) |
                                 (r_state == S_CALC) |
                                 (r_state == S_FIX));
    assign MulDone   = (r_state == S_DONE) & ~Abort;
    assign MulResult = r_result;
    assign MulWA3    = r_wa3_out;
    assign MulN      = r_n;
    assign MulZ      = r_z;

endmodule

// File: tb/tb_exec_mul_unit.sv
// Scoreboard bench for exec_mul_unit: cycle-exact stall/strobe timing
// and products checked against a 96-bit reference multiply.
module tb_exec_mul_unit;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        MulStartE;
    logic        SignedE;
    logic        HighE;
    logic [47:0] SrcAE;
    logic [47:0] SrcBE;
    logic [3:0]  WA3E;
    logic        Abort;
    logic        MulBusy;
    logic        MulDone;
    logic [47:0] MulResult;
    logic [3:0]  MulWA3;
    logic        MulN;
    logic        MulZ;

    typedef struct packed {
        logic [47:0] res;
        logic [3:0]  wa;
        logic        n;
        logic        z;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [47:0] last_res = '0;

    exec_mul_unit dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .MulStartE(MulStartE),
        .SignedE  (SignedE),
        .HighE    (HighE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .WA3E     (WA3E),
        .Abort    (Abort),
        .MulBusy  (MulBusy),
        .MulDone  (MulDone),
        .MulResult(MulResult),
        .MulWA3   (MulWA3),
        .MulN     (MulN),
        .MulZ     (MulZ)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] rnd48();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[47:0];
    endfunction

    always @(negedge CLK) begin
        if (MulDone) begin
            chk("sb_pending", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", 64'(MulResult), 64'(e.res));
                chk("wa3", 64'(MulWA3), 64'(e.wa));
                chk("flag_n", 64'(MulN), 64'(e.n));
                chk("flag_z", 64'(MulZ), 64'(e.z));
            end
        end
    end

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    // Caller is 1 time unit past a rising edge; abort_at < 0 = no abort.
    task automatic run_mul(input logic [47:0] a, input logic [47:0] b,
                           input logic s, input logic h,
                           input logic [3:0] wa, input int abort_at);
        logic [95:0] ax, bx, p;
        exp_t        e;
        ax = s ? {{48{a[47]}}, a} : {48'b0, a};
        bx = s ? {{48{b[47]}}, b} : {48'b0, b};
        p  = ax * bx;
        e.res = h ? p[95:48] : p[47:0];
        e.wa  = wa;
        e.n   = e.res[47];
        e.z   = (e.res == '0);
        if (abort_at < 0) sb_q.push_back(e);
        for (int c = 0; c <= 26; c++) begin
            MulStartE = 1'b1;
            SignedE   = s;
            HighE     = h;
            SrcAE     = (c == 0) ? a : rnd48();
            SrcBE     = (c == 0) ? b : rnd48();
            WA3E      = (c == 0) ? wa : 4'($urandom());
            Abort     = (c == abort_at);
            @(negedge CLK);
            if (c == abort_at) begin
                chk("busy_abort", 64'(MulBusy), 64'd0);
                chk("hold_abort", 64'(MulResult), 64'(last_res));
                next_cyc();
                Abort     = 1'b0;
                MulStartE = 1'b0;
                return;
            end
            chk($sformatf("busy_c%0d", c), 64'(MulBusy), 64'(c <= 25));
            chk($sformatf("done_c%0d", c), 64'(MulDone), 64'(c == 26));
            if (c == 25) chk("hold", 64'(MulResult), 64'(last_res));
            next_cyc();
        end
        MulStartE = 1'b0;
        last_res  = e.res;
        @(negedge CLK);
        chk("done_after", 64'(MulDone), 64'd0);
        chk("busy_after", 64'(MulBusy), 64'd0);
        next_cyc();
    endtask

    initial begin
        CLR = 1'b1; MulStartE = 1'b0; SignedE = 1'b0; HighE = 1'b0;
        SrcAE = '0; SrcBE = '0; WA3E = '0; Abort = 1'b0;
        next_cyc();
        next_cyc();
        CLR = 1'b0;
        @(negedge CLK);
        chk("rst_busy", 64'(MulBusy), 64'd0);
        chk("rst_done", 64'(MulDone), 64'd0);
        chk("rst_res", 64'(MulResult), 64'd0);
        chk("rst_wa3", 64'(MulWA3), 64'd0);
        chk("rst_nz", 64'({MulN, MulZ}), 64'd0);
        next_cyc();

        run_mul(48'd3, 48'd5, 1'b0, 1'b0, 4'h7, -1);
        run_mul('1, 48'd1, 1'b1, 1'b1, 4'h2, -1);
        run_mul('1, 48'd1, 1'b1, 1'b0, 4'h3, -1);
        run_mul('1, '1, 1'b0, 1'b1, 4'h4, -1);
        run_mul('1, '1, 1'b0, 1'b0, 4'h5, -1);
        run_mul(48'h8000_0000_0000, 48'h8000_0000_0000, 1'b1, 1'b1, 4'h6, -1);
        run_mul(48'h8000_0000_0000, 48'h8000_0000_0000, 1'b1, 1'b0, 4'h8, -1);

        run_mul(48'd1234, 48'd5678, 1'b0, 1'b0, 4'h9, 10);
        run_mul(48'd1234, 48'h8000_0000_0001, 1'b1, 1'b0, 4'hA, -1);

        for (int c = 0; c <= 5; c++) begin
            MulStartE = 1'b1;
            SrcAE = 48'd77; SrcBE = 48'd99; WA3E = 4'hB;
            CLR = (c == 5);
            next_cyc();
        end
        CLR = 1'b0;
        MulStartE = 1'b0;
        #1;
        chk("clr_busy0", 64'(MulBusy), 64'd0);
        chk("clr_done", 64'(MulDone), 64'd0);
        chk("clr_res", 64'(MulResult), 64'd0);
        chk("clr_wa3", 64'(MulWA3), 64'd0);
        chk("clr_nz", 64'({MulN, MulZ}), 64'd0);
        MulStartE = 1'b1;
        #1;
        chk("clr_busy1", 64'(MulBusy), 64'd1);
        MulStartE = 1'b0;
        last_res = '0;
        next_cyc();

        for (int i = 0; i < 4; i++) begin
            run_mul(rnd48(), rnd48(), 1'($urandom()), 1'($urandom()),
                    4'($urandom()), -1);
        end

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_mul_unit.md
Name: exec_mul_unit

Overview:
- Iterative multiply unit in the Execute stage of the pipelined CPU.
- Fed by the forwarded execute operands (RE1/RE2 after forwarding muxes) and by WA3E from the Decode/Execute register.
- Raises a stall request to the hazard unit while it computes.
- Delivers the SIZE-bit product slice, destination register and N/Z flags to the Execute/Memory register in a single DONE cycle.

Parameters:
- SIZE, 48: datapath width; operands and result are SIZE bits.
- BITS_PER_CYCLE, 2: multiplier bits retired per CALC cycle. Must divide SIZE. N = SIZE/BITS_PER_CYCLE (default 24).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CLR  in  1  reset, synchronous, active-high; highest priority.
- MulStartE  in  1  execute-stage instruction is a multiply; held high while the instruction sits in E.
- SignedE  in  1  1 = operands are two's complement; 0 = unsigned.
- HighE  in  1  1 = return upper SIZE bits of the 2*SIZE product; 0 = lower SIZE bits.
- SrcAE  in  SIZE  multiplicand.
- SrcBE  in  SIZE  multiplier.
- WA3E  in  4  destination register of the multiply.
- Abort  in  1  flush of E (taken branch); cancels any operation.
- MulBusy  out  1  stall request to hazard unit (freeze F/D/E).
- MulDone  out  1  one-cycle result-valid strobe.
- MulResult  out  SIZE  selected product slice.
- MulWA3  out  4  destination captured at start.
- MulN  out  1  MulResult[SIZE-1].
- MulZ  out  1  MulResult == 0.

Behaviour:
- Reset (CLR=1 at rising edge): state IDLE; MulResult=0, MulWA3=0, MulN=0, MulZ=0, MulDone=0; internal accumulator and counter cleared. MulBusy=0 in the following cycle.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On MulStartE=1 and Abort=0, capture the operands, SignedE, HighE and WA3E.
  - When SignedE=1, store magnitudes |SrcAE|, |SrcBE| and sign = SrcAE[SIZE-1]^SrcBE[SIZE-1]; otherwise sign=0.
  - Clear the 2*SIZE accumulator and counter, then go to CALC.
- CALC:
  - Each cycle, add multiplicand * (next BITS_PER_CYCLE multiplier bits, LSB first), shifted into position, to the accumulator. Increment the counter.
  - After N cycles go to FIX.
  - All arithmetic is unsigned on magnitudes, with 2*SIZE-bit accumulator width. No overflow is possible: the magnitude of -2^(SIZE-1) fits in SIZE unsigned bits.
- FIX:
  - If sign=1, two's-complement the full 2*SIZE product.
  - Select the upper half if HighE, else the lower half.
  - Register MulResult, MulN and MulZ; load MulWA3. Go to DONE.
- DONE:
  - MulDone=1 for exactly this cycle. Always go to IDLE next.
  - MulStartE is ignored here, because the same multiply instruction is still in E. A following multiply starts from IDLE.
- Latency: MulStartE first high in cycle 0 (state IDLE) → CALC cycles 1..N → FIX cycle N+1 → DONE cycle N+2. Default: MulDone in cycle 26.
- MulBusy is combinational: (state==IDLE & MulStartE) | state==CALC | state==FIX, forced to 0 when Abort=1.
  - Default: MulBusy high cycles 0..25, low in DONE cycle 26, so the pipeline advances and E/M captures the result.
- Abort=1 in any state (CLR=0): next state IDLE; MulDone never asserted for the cancelled operation; output registers keep their previous values. Start is not accepted in the same cycle as Abort.
- Output hold: MulResult, MulWA3, MulN and MulZ hold their last values outside DONE and change only on the FIX→DONE edge or on CLR.
- Operand changes on SrcAE/SrcBE after cycle 0 have no effect.
- CLR mid-operation: identical to reset, and takes priority over Abort and MulStartE.

Test Plan:
- Unsigned low: SrcAE=3, SrcBE=5, SignedE=0, HighE=0, WA3E=4'h7 → MulBusy high cycles 0..25; MulDone only in cycle 26; MulResult=15, MulWA3=7, N=0, Z=0.
- Signed: SrcAE=48'hFFFF_FFFF_FFFF (-1), SrcBE=1, SignedE=1 → HighE=1: MulResult=48'hFFFF_FFFF_FFFF, N=1, Z=0. HighE=0 gives the same value.
- Unsigned high/low: both operands 48'hFFFF_FFFF_FFFF, SignedE=0 → HighE=1: 48'hFFFF_FFFF_FFFE. HighE=0: 48'h0000_0000_0001.
- Signed min×min: both 48'h8000_0000_0000, SignedE=1 → HighE=1: 48'h4000_0000_0000, Z=0. HighE=0: 0, Z=1, N=0.
- Abort: start cycle 0, Abort=1 in cycle 10 → MulBusy=0 in cycle 10; IDLE in cycle 11; no MulDone. A new start in cycle 11 yields MulDone in cycle 37.
- CLR in cycle 5 mid-CALC → cycle 6: IDLE, all outputs 0, MulBusy follows MulStartE. Separately, MulStartE held through DONE → exactly one MulDone, no restart in the DONE cycle.
